// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a simple request/ack word bus.
// Handles B/H/W stores with lane replication and B/H/W/BU/HU loads with extension.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_memread,
  input  logic        sig_memwrite,
  input  logic [2:0]  sig_memrdwidth,
  input  logic [1:0]  sig_memwrwidth,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        load_valid,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  localparam logic [2:0] RD_B  = 3'd1;
  localparam logic [2:0] RD_H  = 3'd2;
  localparam logic [2:0] RD_W  = 3'd3;
  localparam logic [2:0] RD_BU = 3'd4;
  localparam logic [2:0] RD_HU = 3'd5;

  localparam logic [1:0] WR_B = 2'd1;
  localparam logic [1:0] WR_H = 2'd2;
  localparam logic [1:0] WR_W = 2'd3;

  state_t      state, next_state;

  logic        req_store;
  size_t       req_sz;
  logic        req_sext;
  logic        req_mis;
  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;

  size_t       ld_sz;
  logic        ld_sext;
  logic [1:0]  ld_off;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;
  logic        ld_done;

  // Request decode: a load masks any simultaneous store.
  always_comb begin
    req_store = ~sig_memread & sig_memwrite;
    req_sz    = SZ_NONE;
    req_sext  = 1'b0;
    if (sig_memread) begin
      case (sig_memrdwidth)
        RD_B:    begin req_sz = SZ_BYTE; req_sext = 1'b1; end
        RD_H:    begin req_sz = SZ_HALF; req_sext = 1'b1; end
        RD_W:    req_sz = SZ_WORD;
        RD_BU:   req_sz = SZ_BYTE;
        RD_HU:   req_sz = SZ_HALF;
        default: req_sz = SZ_NONE;
      endcase
    end else if (req_store) begin
      case (sig_memwrwidth)
        WR_B:    req_sz = SZ_BYTE;
        WR_H:    req_sz = SZ_HALF;
        WR_W:    req_sz = SZ_WORD;
        default: req_sz = SZ_NONE;
      endcase
    end
  end

  always_comb begin
    req_mis   = ((req_sz == SZ_HALF) && addr[0]) ||
                ((req_sz == SZ_WORD) && (addr[1:0] != 2'b00));
    req_legal = (req_sz != SZ_NONE) && !req_mis;
    case (req_sz)
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr[1:0];
        req_lanes = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << addr[1:0];
        req_lanes = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        req_be    = '1;
        req_lanes = wdata;
      end
      default: begin
        req_be    = '0;
        req_lanes = '0;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_legal) next_state = BUSY;
      BUSY:    if (bus_ack) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gated by rst so the stall cannot leak from live inputs while held in reset.
  always_comb begin
    mem_stall = rst && (((state == IDLE) && req_legal) || (state == BUSY));
  end

  always_comb begin
    ld_done  = (state == BUSY) && bus_ack && !bus_we;
    rd_shift = bus_rdata >> {ld_off, 3'b000};
    case (ld_sz)
      SZ_BYTE: ld_ext = ld_sext ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                : {24'b0, rd_shift[7:0]};
      SZ_HALF: ld_ext = ld_sext ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                : {16'b0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      ld_sz      <= SZ_NONE;
      ld_sext    <= 1'b0;
      ld_off     <= '0;
      rdata_out  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state      <= next_state;
      bus_req    <= (next_state == BUSY);
      load_valid <= ld_done;
      // A persisting misaligned request pulses only on alternate cycles.
      misalign   <= (state == IDLE) && req_mis && !misalign;
      if ((state == IDLE) && req_legal) begin
        bus_addr  <= {addr[31:2], 2'b00};
        bus_we    <= req_store;
        bus_be    <= req_be;
        bus_wdata <= req_store ? req_lanes : '0;
        ld_sz     <= req_sz;
        ld_sext   <= req_sext;
        ld_off    <= addr[1:0];
      end
      if (ld_done) begin
        rdata_out <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalignment, priority, reset.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        sig_memread;
  logic        sig_memwrite;
  logic [2:0]  sig_memrdwidth;
  logic [1:0]  sig_memwrwidth;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        load_valid;
  logic        mem_stall;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vectors;
  int miscompares;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .sig_memread    (sig_memread),
    .sig_memwrite   (sig_memwrite),
    .sig_memrdwidth (sig_memrdwidth),
    .sig_memwrwidth (sig_memwrwidth),
    .addr           (addr),
    .wdata          (wdata),
    .rdata_out      (rdata_out),
    .load_valid     (load_valid),
    .mem_stall      (mem_stall),
    .misalign       (misalign),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sig_memread    = 1'b0;
    sig_memwrite   = 1'b0;
    sig_memrdwidth = 3'd0;
    sig_memwrwidth = 2'd0;
    addr           = '0;
    wdata          = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus_ack     = 1'b0;
    bus_rdata   = '0;
    idle_inputs();

    // Reset state, with a legal request present to prove stall is gated.
    #2;
    sig_memwrite   = 1'b1;
    sig_memwrwidth = 2'd3;
    addr           = 32'h0000_0100;
    #1;
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_bus_req", {31'b0, bus_req}, 32'd0);

    // SB at 0x1003, immediate ack; request held through DONE.
    sig_memwrite   = 1'b1;
    sig_memwrwidth = 2'd1;
    addr           = 32'h0000_1003;
    wdata          = 32'h0000_00AB;
    #1;
    chk("sb_idle_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    chk("sb_bus_req", {31'b0, bus_req}, 32'd1);
    chk("sb_bus_we", {31'b0, bus_we}, 32'd1);
    chk("sb_bus_be", {28'b0, bus_be}, 32'h8);
    chk("sb_bus_wdata", bus_wdata, 32'hABAB_ABAB);
    chk("sb_bus_addr", bus_addr, 32'h0000_1000);
    chk("sb_busy_stall", {31'b0, mem_stall}, 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("sb_done_stall", {31'b0, mem_stall}, 32'd0);
    chk("sb_done_bus_req", {31'b0, bus_req}, 32'd0);
    chk("sb_done_load_valid", {31'b0, load_valid}, 32'd0);
    tick();
    chk("sb_no_start_from_done", {31'b0, bus_req}, 32'd0);
    chk("sb_reeval_in_idle", {31'b0, mem_stall}, 32'd1);
    idle_inputs();
    #1;
    chk("sb_release_stall", {31'b0, mem_stall}, 32'd0);
    tick();

    // SH at 0x0002: upper half lanes.
    sig_memwrite   = 1'b1;
    sig_memwrwidth = 2'd2;
    addr           = 32'h0000_0002;
    wdata          = 32'h1234_5678;
    tick();
    chk("sh_bus_be", {28'b0, bus_be}, 32'hC);
    chk("sh_bus_wdata", bus_wdata, 32'h5678_5678);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    idle_inputs();
    tick();

    // LB at 0x2001, two wait cycles: IDLE, BUSY, BUSY, BUSY+ack, DONE.
    sig_memread    = 1'b1;
    sig_memrdwidth = 3'd1;
    addr           = 32'h0000_2001;
    #1;
    chk("lb_c1_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    chk("lb_c2_bus_req", {31'b0, bus_req}, 32'd1);
    chk("lb_c2_bus_we", {31'b0, bus_we}, 32'd0);
    chk("lb_c2_bus_be", {28'b0, bus_be}, 32'h2);
    chk("lb_c2_bus_addr", bus_addr, 32'h0000_2000);
    tick();
    chk("lb_c3_bus_req", {31'b0, bus_req}, 32'd1);
    chk("lb_c3_stall", {31'b0, mem_stall}, 32'd1);
    chk("lb_c3_load_valid", {31'b0, load_valid}, 32'd0);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_8000;
    chk("lb_c4_bus_req", {31'b0, bus_req}, 32'd1);
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    chk("lb_c5_load_valid", {31'b0, load_valid}, 32'd1);
    chk("lb_c5_rdata", rdata_out, 32'hFFFF_FF80);
    chk("lb_c5_stall", {31'b0, mem_stall}, 32'd0);
    chk("lb_c5_bus_req", {31'b0, bus_req}, 32'd0);
    idle_inputs();
    tick();
    chk("lb_after_load_valid", {31'b0, load_valid}, 32'd0);
    chk("lb_rdata_hold", rdata_out, 32'hFFFF_FF80);

    // LHU at 0x2002.
    sig_memread    = 1'b1;
    sig_memrdwidth = 3'd5;
    addr           = 32'h0000_2002;
    tick();
    chk("lhu_bus_be", {28'b0, bus_be}, 32'hC);
    bus_ack   = 1'b1;
    bus_rdata = 32'h8001_0000;
    tick();
    bus_ack = 1'b0;
    chk("lhu_rdata", rdata_out, 32'h0000_8001);
    chk("lhu_load_valid", {31'b0, load_valid}, 32'd1);
    idle_inputs();
    tick();

    // LW misaligned at 0x3002, request held for two cycles.
    sig_memread    = 1'b1;
    sig_memrdwidth = 3'd3;
    addr           = 32'h0000_3002;
    #1;
    chk("lwm_idle_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("lwm_misalign", {31'b0, misalign}, 32'd1);
    chk("lwm_bus_req", {31'b0, bus_req}, 32'd0);
    chk("lwm_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("lwm_no_repulse", {31'b0, misalign}, 32'd0);
    chk("lwm_bus_req2", {31'b0, bus_req}, 32'd0);
    idle_inputs();
    tick();
    chk("lwm_clear", {31'b0, misalign}, 32'd0);

    // Read and write together: LW at 0x4000 wins.
    sig_memread    = 1'b1;
    sig_memwrite   = 1'b1;
    sig_memrdwidth = 3'd3;
    sig_memwrwidth = 2'd1;
    addr           = 32'h0000_4000;
    wdata          = 32'h0000_00FF;
    tick();
    chk("both_bus_we", {31'b0, bus_we}, 32'd0);
    chk("both_bus_be", {28'b0, bus_be}, 32'hF);
    chk("both_bus_addr", bus_addr, 32'h0000_4000);
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    chk("both_load_valid", {31'b0, load_valid}, 32'd1);
    chk("both_rdata", rdata_out, 32'hDEAD_BEEF);
    idle_inputs();
    tick();

    // UNUSED widths: no access, no stall.
    sig_memread    = 1'b1;
    sig_memrdwidth = 3'd6;
    #1;
    chk("unused_rd_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("unused_rd_bus_req", {31'b0, bus_req}, 32'd0);
    sig_memread    = 1'b0;
    sig_memwrite   = 1'b1;
    sig_memwrwidth = 2'd0;
    #1;
    chk("unused_wr_stall", {31'b0, mem_stall}, 32'd0);
    idle_inputs();
    tick();

    // Reset during BUSY, then a late ack.
    sig_memread    = 1'b1;
    sig_memrdwidth = 3'd1;
    addr           = 32'h0000_5001;
    tick();
    chk("rb_busy_bus_req", {31'b0, bus_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rb_stall", {31'b0, mem_stall}, 32'd0);
    chk("rb_rdata", rdata_out, 32'd0);
    chk("rb_bus_be", {28'b0, bus_be}, 32'd0);
    idle_inputs();
    tick();
    rst       = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_0080;
    tick();
    chk("rb_ack_load_valid", {31'b0, load_valid}, 32'd0);
    chk("rb_ack_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rb_ack_rdata", rdata_out, 32'd0);
    chk("rb_idle_stall", {31'b0, mem_stall}, 32'd0);
    bus_ack = 1'b0;
    tick();
    chk("rb_after_load_valid", {31'b0, load_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
REQ-002 The block SHALL provide these pipeline-side ports, all sampled on the rising edge of clk:
- sig_memread  in  1  load request
- sig_memwrite  in  1  store request
- sig_memrdwidth  in  3  0=UNUSED, 1=B, 2=H, 3=W, 4=BU, 5=HU, 6/7 = UNUSED
- sig_memwrwidth  in  2  0=UNUSED, 1=B, 2=H, 3=W
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rdata_out  out  32  extended load result
- load_valid  out  1  rdata_out valid this cycle
- mem_stall  out  1  pipeline lock request
- misalign  out  1  misaligned-access pulse
REQ-003 The block SHALL provide these bus-side ports:
- bus_req  out  1  request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, bits [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_ack  in  1  request accepted and completed
- bus_rdata  in  32  read data, valid when bus_ack = 1

Function
REQ-004 A load (sig_memread=1) SHALL take priority over a store; when sig_memread=1, sig_memwrite SHALL be ignored.
REQ-005 A request whose selected width is UNUSED SHALL perform no access and SHALL NOT assert mem_stall.
REQ-006 Access type SHALL be decided as follows:
- H/HU/half store with addr[0]=1: misaligned
- W/word store with addr[1:0]!=0: misaligned
- any other valid width and address: legal
REQ-007 The FSM SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE -> BUSY on a legal request
- BUSY -> DONE on bus_ack=1
- DONE -> IDLE unconditionally
REQ-008 mem_stall SHALL be a combinational output: 1 in IDLE while a legal request is present, 1 in BUSY, 0 in DONE.
REQ-009 On the IDLE->BUSY edge, bus_addr, bus_we, bus_be and bus_wdata SHALL be registered; these signals SHALL hold stable throughout BUSY.
REQ-010 bus_req SHALL be registered and equal 1 exactly while in BUSY.
REQ-011 Store byte enables SHALL be:
- B: 4'b0001<<addr[1:0]
- H: 4'b0011<<addr[1:0]
- W: 4'b1111
REQ-012 Store data SHALL be lane-replicated: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
REQ-013 Loads SHALL drive bus_be per REQ-011 and bus_we=0.
REQ-014 On bus_ack in BUSY, the block SHALL extract the byte or half at offset addr[1:0] from bus_rdata and extend it: B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-015 rdata_out SHALL be registered from the REQ-014 result and SHALL hold until the next load completes.
REQ-016 load_valid SHALL be 1 only in DONE following a load.
REQ-017 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with immediate ack, DONE); each cycle without ack in BUSY SHALL add one cycle.
REQ-018 A misaligned request seen in IDLE SHALL produce the following response:
- no bus access
- mem_stall=0
- misalign=1 registered, for exactly one cycle
- misalign SHALL NOT re-pulse in the next cycle if the same request persists; that cycle is treated as a new instruction
REQ-019 bus_ack SHALL be ignored in IDLE and DONE.
REQ-020 Requests present during DONE SHALL NOT start an access; they SHALL be evaluated in IDLE on the following cycle.

Reset
REQ-021 Asserting rst (low) SHALL immediately and asynchronously force all of the following:
- state IDLE
- bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0
- rdata_out=0, load_valid=0, misalign=0
- mem_stall SHALL be 0 during reset
REQ-022 Reset asserted mid-BUSY SHALL abandon the access; a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-023 The bench SHALL cover each of the following directed scenarios:
- SB: addr=0x1003, wdata=0xAB -> bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x1000, bus_we=1; mem_stall high until DONE.
- LB: addr=0x2001, bus_rdata=0x0000_8000, ack after 2 wait cycles -> rdata_out=0xFFFFFF80, load_valid one cycle, 5 cycles total.
- LHU: addr=0x2002, bus_rdata=0x8001_0000 -> rdata_out=0x00008001.
- LW: addr=0x3002 -> misalign pulses one cycle, bus_req stays 0, mem_stall stays 0.
- Both sig_memread and sig_memwrite set, LW at 0x4000 -> bus_we=0, only a read performed.
- rst low during BUSY, then bus_ack -> bus_req=0 immediately, no load_valid, state IDLE.
